// File: rtl/router_pkg.sv
// Shared router definitions: output-direction encoding and the XY routing rule
// used by every input port.
package router_pkg;

  localparam int unsigned ROUT_DIR_W = 3;

  typedef enum logic [ROUT_DIR_W-1:0] {
    DIR_NORTH = 3'd0,
    DIR_EAST  = 3'd1,
    DIR_SOUTH = 3'd2,
    DIR_WEST  = 3'd3,
    DIR_LOCAL = 3'd4
  } rout_dir_e;

  // Dimension-ordered routing: resolve x first, then y, else deliver locally.
  function automatic rout_dir_e xy_route(input logic [3:0] dst_x,
                                         input logic [3:0] dst_y,
                                         input logic [3:0] my_x,
                                         input logic [3:0] my_y);
    if (dst_x > my_x)      return DIR_EAST;
    else if (dst_x < my_x) return DIR_WEST;
    else if (dst_y > my_y) return DIR_NORTH;
    else if (dst_y < my_y) return DIR_SOUTH;
    else                   return DIR_LOCAL;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Generic synchronous FIFO with async active-low reset and an occupancy count
// that carries one extra bit so full and empty are distinct.
module router_fifo #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [FW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign fill    = count;

  // Storage is reset too so the head output reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/router_in_port.sv
// Mesh router input port: XY route at ingress, buffer {flit, direction}, present to crossbar.
// Optional macro ROUTER_IN_DST_CHECK_EN drops and counts flits addressed outside the mesh.
`ifndef ROUTER_BUS_W
`define ROUTER_BUS_W 32
`endif

module router_in_port
  import router_pkg::*;
#(
  parameter int unsigned DATA_W = `ROUTER_BUS_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned MY_X   = 0,
  parameter int unsigned MY_Y   = 0,
  parameter int unsigned MESH_X = 4,
  parameter int unsigned MESH_Y = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [DATA_W-1:0]         s_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic [2:0]                m_tdest,
  output logic [$clog2(DEPTH):0]    fill,
  output logic [15:0]               err_cnt
);

  localparam int unsigned EW = DATA_W + ROUT_DIR_W;

  logic [3:0]    dst_x;
  logic [3:0]    dst_y;
  rout_dir_e     dir;
  logic          accept;
  logic          store;
  logic          full;
  logic          empty;
  logic [EW-1:0] head;

  assign dst_x  = s_tdata[DATA_W-9 -: 4];
  assign dst_y  = s_tdata[DATA_W-13 -: 4];
  assign dir    = xy_route(dst_x, dst_y, 4'(MY_X), 4'(MY_Y));
  assign accept = s_tvalid && s_tready;

  assign s_tready = !full;
  assign m_tvalid = !empty;
  assign m_tdata  = head[EW-1:ROUT_DIR_W];
  assign m_tdest  = head[ROUT_DIR_W-1:0];

`ifdef ROUTER_IN_DST_CHECK_EN
  logic drop;

  // Out-of-mesh flits still complete the handshake so the sender never stalls on them.
  assign drop  = (32'(dst_x) >= MESH_X) || (32'(dst_y) >= MESH_Y);
  assign store = accept && !drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  err_cnt <= '0;
    else if (accept && drop && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
  end
`else
  assign store   = accept;
  assign err_cnt = '0;
`endif

  router_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (store),
    .wdata ({s_tdata, dir}),
    .pop   (m_tvalid && m_tready),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .fill  (fill)
  );

endmodule

// File: tb/tb_router_in_port.sv
// Self-checking bench for router_in_port (router at (1,1) in a 4x4 mesh, DEPTH=4).
`ifndef ROUTER_BUS_W
`define ROUTER_BUS_W 32
`endif

module tb_router_in_port;

  localparam int DW    = `ROUTER_BUS_W;
  localparam int DEPTH = 4;
  localparam int MYX   = 1;
  localparam int MYY   = 1;
  localparam int MESHX = 4;
  localparam int MESHY = 4;
  localparam int FW    = $clog2(DEPTH) + 1;
`ifdef ROUTER_IN_DST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [2:0]    m_tdest;
  logic [FW-1:0] fill;
  logic [15:0]   err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [2:0]    dir;
  } ent_t;

  ent_t        q[$];
  int unsigned m_err = 0;

  router_in_port #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .MY_X   (MYX),
    .MY_Y   (MYY),
    .MESH_X (MESHX),
    .MESH_Y (MESHY)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tdest  (m_tdest),
    .fill     (fill),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Direction from signed coordinate differences: x resolved before y.
  function automatic logic [2:0] ref_dir(input logic [DW-1:0] f);
    int dx, dy;
    dx = int'(f[DW-9 -: 4]) - MYX;
    dy = int'(f[DW-13 -: 4]) - MYY;
    if (dx > 0) return 3'd1;
    if (dx < 0) return 3'd3;
    if (dy > 0) return 3'd0;
    if (dy < 0) return 3'd2;
    return 3'd4;
  endfunction

  function automatic bit ref_oom(input logic [DW-1:0] f);
    return CHK && ((int'(f[DW-9 -: 4]) >= MESHX) || (int'(f[DW-13 -: 4]) >= MESHY));
  endfunction

  function automatic logic [DW-1:0] mk(input int dx, input int dy);
    logic [DW-1:0] f;
    f = DW'({$urandom, $urandom});
    f[DW-9 -: 4]  = 4'(dx);
    f[DW-13 -: 4] = 4'(dy);
    return f;
  endfunction

  // Advance one clock and apply the handshake rules to the reference queue.
  task automatic cycle();
    bit acc, pop;
    @(posedge clk);
    acc = s_tvalid && (q.size() != DEPTH);
    pop = m_tready && (q.size() != 0);
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (ref_oom(s_tdata)) begin
        if (m_err != 16'hFFFF) m_err++;
      end else begin
        q.push_back('{data: s_tdata, dir: ref_dir(s_tdata)});
      end
    end
    #1;
  endtask

  task automatic test_reset();
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready: got %b expected 1", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b expected 0", m_tvalid); end
    checks++; if (m_tdata !== '0) begin errors++; $display("FAIL reset_m_tdata: got %h expected 0", m_tdata); end
    checks++; if (m_tdest !== 3'd0) begin errors++; $display("FAIL reset_m_tdest: got %0d expected 0", m_tdest); end
    checks++; if (fill !== '0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_routing();
    int dxs[5] = '{2, 0, 1, 1, 1};
    int dys[5] = '{1, 1, 2, 0, 1};
    int exp_d[5] = '{1, 3, 0, 2, 4};
    logic [DW-1:0] f;
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f = mk(dxs[i], dys[i]);
      s_tvalid = 1'b1;
      s_tdata  = f;
      cycle();
      checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL route_valid[%0d]: got %b expected 1", i, m_tvalid); end
      checks++; if (m_tdest !== 3'(exp_d[i])) begin errors++; $display("FAIL route_dest[%0d]: got %0d expected %0d", i, m_tdest, exp_d[i]); end
      checks++; if (m_tdata !== f) begin errors++; $display("FAIL route_data[%0d]: got %h expected %h", i, m_tdata, f); end
    end
    s_tvalid = 1'b0;
    cycle();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL route_drained: got %b expected 0", m_tvalid); end
  endtask

  task automatic test_full();
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (s_tready !== (i < DEPTH)) begin errors++; $display("FAIL full_ready[%0d]: got %b expected %b", i, s_tready, i < DEPTH); end
      s_tvalid = 1'b1;
      s_tdata  = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      cycle();
      checks++; if (fill !== FW'((i < DEPTH) ? i + 1 : DEPTH)) begin errors++; $display("FAIL full_fill[%0d]: got %0d expected %0d", i, fill, (i < DEPTH) ? i + 1 : DEPTH); end
    end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL full_not_ready: got %b expected 0", s_tready); end
    // full with simultaneous push and pop: push is refused
    m_tready = 1'b1;
    s_tdata  = mk(3, 3);
    cycle();
    checks++; if (fill !== FW'(3)) begin errors++; $display("FAIL full_popnopush_fill: got %0d expected 3", fill); end
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL full_popnopush_ready: got %b expected 1", s_tready); end
    m_tready = 1'b0;
    s_tdata  = mk(0, 0);
    cycle();
    checks++; if (fill !== FW'(4)) begin errors++; $display("FAIL full_refill: got %0d expected 4", fill); end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int n = 0; n < 10 && q.size() != 0; n++) begin
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== q[0].data || m_tdest !== q[0].dir) begin
        errors++; $display("FAIL full_drain[%0d]: got v=%b d=%h t=%0d expected v=1 d=%h t=%0d", n, m_tvalid, m_tdata, m_tdest, q[0].data, q[0].dir);
      end
      cycle();
    end
    checks++; if (m_tvalid !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL full_empty: got v=%b expected 0 (model size %0d)", m_tvalid, q.size()); end
  endtask

  task automatic test_back_to_back();
    m_tready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      cycle();
      checks++; if (m_tvalid !== 1'b1 || fill !== FW'(1) || m_tdata !== q[0].data || m_tdest !== q[0].dir) begin
        errors++; $display("FAIL b2b[%0d]: got v=%b f=%0d d=%h t=%0d expected v=1 f=1 d=%h t=%0d", i, m_tvalid, fill, m_tdata, m_tdest, q[0].data, q[0].dir);
      end
    end
    s_tvalid = 1'b0;
    cycle();
    checks++; if (fill !== '0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL b2b_end: got f=%0d v=%b expected 0 0", fill, m_tvalid); end
  endtask

  task automatic test_dst_check();
    logic [DW-1:0] fa, fb;
    fa = mk(5, 0);
    fb = mk(2, 2);
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = fa;
    cycle();
    s_tdata  = fb;
    cycle();
    s_tvalid = 1'b0;
    checks++; if (err_cnt !== 16'(m_err) || m_err != (CHK ? 1 : 0)) begin errors++; $display("FAIL dst_err_cnt: got %0d expected %0d", err_cnt, CHK ? 1 : 0); end
    checks++; if (fill !== FW'(CHK ? 1 : 2)) begin errors++; $display("FAIL dst_fill: got %0d expected %0d", fill, CHK ? 1 : 2); end
    m_tready = 1'b1;
    if (!CHK) begin
      checks++; if (m_tdata !== fa || m_tdest !== 3'd1) begin errors++; $display("FAIL dst_first: got d=%h t=%0d expected d=%h t=1", m_tdata, m_tdest, fa); end
      cycle();
    end
    checks++; if (m_tdata !== fb || m_tdest !== 3'd1) begin errors++; $display("FAIL dst_second: got d=%h t=%0d expected d=%h t=1", m_tdata, m_tdest, fb); end
    cycle();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL dst_empty: got %b expected 0", m_tvalid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      s_tvalid = 1'($urandom_range(0, 1));
      m_tready = ($urandom_range(0, 3) != 0);
      s_tdata  = mk(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      checks++; if (s_tready !== (q.size() != DEPTH)) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, s_tready, q.size() != DEPTH); end
      cycle();
      checks++; if (fill !== FW'(q.size()) || m_tvalid !== (q.size() != 0) || err_cnt !== 16'(m_err)) begin
        errors++; $display("FAIL rand_state[%0d]: got f=%0d v=%b e=%0d expected f=%0d v=%b e=%0d", i, fill, m_tvalid, err_cnt, q.size(), q.size() != 0, m_err);
      end
      if (q.size() != 0) begin
        checks++; if (m_tdata !== q[0].data || m_tdest !== q[0].dir) begin
          errors++; $display("FAIL rand_head[%0d]: got d=%h t=%0d expected d=%h t=%0d", i, m_tdata, m_tdest, q[0].data, q[0].dir);
        end
      end
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (DEPTH + 1) cycle();
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] f;
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    repeat (3) begin
      s_tdata = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      cycle();
    end
    s_tvalid = 1'b0;
    checks++; if (fill !== FW'(3)) begin errors++; $display("FAIL areset_prefill: got %0d expected 3", fill); end
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_err = 0;
    checks++; if (m_tvalid !== 1'b0 || fill !== '0 || err_cnt !== 16'd0 || s_tready !== 1'b1) begin
      errors++; $display("FAIL areset_immediate: got v=%b f=%0d e=%0d r=%b expected 0 0 0 1", m_tvalid, fill, err_cnt, s_tready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    f = mk(3, 3);
    s_tvalid = 1'b1;
    s_tdata  = f;
    cycle();
    s_tvalid = 1'b0;
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== f || m_tdest !== 3'd1 || fill !== FW'(1)) begin
      errors++; $display("FAIL areset_after: got v=%b d=%h t=%0d f=%0d expected v=1 d=%h t=1 f=1", m_tvalid, m_tdata, m_tdest, fill, f);
    end
    m_tready = 1'b1;
    cycle();
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL areset_drain: got %b expected 0", m_tvalid); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_routing();
    test_full();
    test_back_to_back();
    test_dst_check();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_in_port.md
# router_in_port

Input port stage of the mesh router: accepts single-flit router messages on an AXI-stream slave, computes the XY output direction at ingress, buffers message plus direction in a small FIFO, and presents them on an AXI-stream master to the switch/crossbar stage. One instance per router input (N, E, S, W, Local); the downstream crossbar consumes `m_tdest` as its output-select.

## Interface
Parameters:
- `DATA_W`, `` `ROUTER_BUS_W ``: flit width. Bit layout: src_x[DATA_W-1:DATA_W-4], src_y, dst_x, dst_y (4 b each), mtype (8 b), payload (DATA_W-24 b).
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `MY_X`, 0: this router's x coordinate, 0..15.
- `MY_Y`, 0: this router's y coordinate, 0..15.
- `MESH_X`, 4: mesh columns, 1..16.
- `MESH_Y`, 4: mesh rows, 1..16.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `s_tvalid` in 1: input flit valid.
- `s_tready` out 1: input ready.
- `s_tdata` in DATA_W: input flit.
- `m_tvalid` out 1: output flit valid.
- `m_tready` in 1: crossbar accepts.
- `m_tdata` out DATA_W: head flit, unmodified.
- `m_tdest` out 3: direction of head flit.
- `fill` out $clog2(DEPTH)+1: entries held.
- `err_cnt` out 16: dropped out-of-mesh flits (see Configuration).

## Operation
- Direction encoding: 0 NORTH, 1 EAST, 2 SOUTH, 3 WEST, 4 LOCAL; 5–7 never produced.
- XY routing on ingress flit: dst_x>MY_X → EAST; dst_x<MY_X → WEST; else dst_y>MY_Y → NORTH; dst_y<MY_Y → SOUTH; else LOCAL. Unsigned 4-bit compares.
- Push when `s_tvalid && s_tready`; {flit, direction} written at write pointer.
- Pop when `m_tvalid && m_tready`; read pointer advances.
- `s_tready = (fill != DEPTH)`. No full-bypass: when full, push refused even if pop in same cycle.
- `m_tvalid = (fill != 0)`; `m_tdata`/`m_tdest` driven from head entry, stable while `m_tvalid && !m_tready`.
- Simultaneous push and pop (not full, not empty): fill unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; fill tracked with extra bit so full/empty are distinguished.
- No FSM; storage plus pointer/counter state only.

## Timing
- Reset values: `s_tready`=1, `m_tvalid`=0, `m_tdata`=0, `m_tdest`=0, `fill`=0, `err_cnt`=0; pointers 0. Reset asserted mid-operation discards all stored flits immediately (async).
- Latency: flit accepted at edge t appears on `m_tvalid`/`m_tdata`/`m_tdest` after edge t (visible cycle t+1); no combinational path s→m.
- `s_tready` depends only on registered fill; `m_tvalid` only on registered fill; no combinational path `m_tready`→`s_tready`.
- Throughput: one flit/cycle sustained when `m_tready` held high.

## Configuration
- Macro `ROUTER_IN_DST_CHECK_EN`.
- Defined: ingress flit with dst_x≥MESH_X or dst_y≥MESH_Y is accepted (`s_tready` handshake completes) but not written; `err_cnt` increments, saturating at 16'hFFFF. Drop consumes no FIFO slot; fill unchanged.
- Undefined: no check; every flit stored and XY-routed as above; `err_cnt` constant 0.

## Structure
- Shared `router_pkg`: direction enum `rout_dir_e` (3 b, values above), `ROUT_DIR_W`=3, helper function `xy_route(dst_x, dst_y, my_x, my_y)` returning `rout_dir_e`, reused by all input ports.
- One sub-module: `router_fifo` (generic synchronous FIFO, width DATA_W+3, depth DEPTH, async active-low reset, fill output). Top handles route compute, drop check and counter.

## Test plan
- MY=(1,1): inject dst=(2,1),(0,1),(1,2),(1,0),(1,1) with `m_tready`=1 → `m_tdest` sequence 1,3,0,2,4, each one cycle after acceptance.
- DEPTH=4, `m_tready`=0, push 5 flits → first 4 accepted, `s_tready`=0 after 4th, fill=4; raise `m_tready` → 4 flits out in order, data unchanged.
- Full FIFO, `s_tvalid`=1 and `m_tready`=1 same cycle → pop occurs, push refused that cycle, fill=3; next cycle push accepted.
- Continuous stream 20 flits, `m_tready`=1 → 20 outputs back-to-back, fill stays ≤1, pointer wrap across 5 laps correct.
- With `ROUTER_IN_DST_CHECK_EN`, MESH=4×4: send dst=(5,0) then (2,2) → first dropped, `err_cnt`=1, only (2,2) emerges; without macro both emerge, (5,0) with tdest EAST, `err_cnt`=0.
- Fill 3 entries, assert `rst_n`=0 asynchronously mid-cycle → `m_tvalid`=0, fill=0, `err_cnt`=0 immediately; after release, new flit passes normally.
